// File: rtl/conv_cfg_pkg.sv
// conv_cfg_pkg: shared FSM state, clog2 and output-geometry helpers for the conv address generators
package conv_cfg_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  function automatic int out_dim(input int in_sz, input int k, input int pad, input int stride);
    return (in_sz + 2 * pad - k) / stride + 1;
  endfunction
  function automatic int kw_pairs(input int kw);
    return (kw + 1) / 2;
  endfunction
endpackage

// File: rtl/conv_addr_gen_stream_if.sv
// conv_addr_gen_stream_if: valid/ready beat carrying a dual-port tap address pair with pad flags
interface conv_addr_gen_stream_if #(parameter int ADDR_W = 11);
  logic addr_valid;
  logic addr_ready;
  logic [ADDR_W-1:0] addra;
  logic [ADDR_W-1:0] addrb;
  logic b_valid;
  logic pad_a;
  logic pad_b;
  logic last;
  modport master (output addr_valid, addra, addrb, b_valid, pad_a, pad_b, last, input addr_ready);
  modport slave (input addr_valid, addra, addrb, b_valid, pad_a, pad_b, last, output addr_ready);
endinterface

// File: rtl/conv_loop_nest_cnt.sv
// conv_loop_nest_cnt: chained wrap counters og>i>j>mg>p>km>kp advancing on adv
module conv_loop_nest_cnt #(
  parameter int W = 8,
  parameter int N_OG = 1,
  parameter int N_OH = 1,
  parameter int N_OW = 1,
  parameter int N_MG = 1,
  parameter int N_PL = 1,
  parameter int N_KH = 1,
  parameter int N_KWP = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic adv,
  output logic [W-1:0] og,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic [W-1:0] mg,
  output logic [W-1:0] p,
  output logic [W-1:0] km,
  output logic [W-1:0] kp,
  output logic [6:0] wrap,
  output logic last
);
  localparam int LIM [7] = '{N_KWP, N_KH, N_PL, N_MG, N_OW, N_OH, N_OG};
  logic [W-1:0] cnt_q [7];
  logic [W-1:0] cnt_d [7];
  logic [6:0] at_max;
  logic [7:0] full;
  for (genvar g = 0; g < 7; g++) begin : g_lvl
    assign at_max[g] = cnt_q[g] == W'(LIM[g] - 1);
    assign wrap[g] = &at_max[g:0];
  end
  // level n steps when every inner level sits at its final value
  assign full = {wrap, 1'b1};
  always_comb begin
    for (int n = 0; n < 7; n++)
      cnt_d[n] = (adv && full[n]) ? (at_max[n] ? '0 : cnt_q[n] + W'(1)) : cnt_q[n];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int n = 0; n < 7; n++) cnt_q[n] <= '0;
    else for (int n = 0; n < 7; n++) cnt_q[n] <= cnt_d[n];
  end
  assign {og, i, j, mg, p, km, kp} = {cnt_q[6], cnt_q[5], cnt_q[4], cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
  assign last = wrap[6];
endmodule

// File: rtl/conv_addr_gen_stream.sv
// conv_addr_gen_stream: streams dual-tap input-map read addresses over the full conv loop nest.
// Define CONV_PAD_EN to honour PAD with pad_a/pad_b flags; otherwise PAD is treated as 0.
module conv_addr_gen_stream import conv_cfg_pkg::*; #(
  parameter int ADDR_W = 11,
  parameter int IN_H = 36,
  parameter int IN_W = 36,
  parameter int KH = 5,
  parameter int KW = 5,
  parameter int STRIDE = 1,
  parameter int PAD = 0,
  parameter int PLANES_PER_MEM = 1,
  parameter int MEM_GROUPS = 1,
  parameter int OUT_GROUPS = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  conv_addr_gen_stream_if.master bus,
  output logic busy,
  output logic done
);
`ifdef CONV_PAD_EN
  localparam int P = PAD;
`else
  localparam int P = 0;
`endif
  localparam int SW = ADDR_W + 2;
  localparam int CW = clog2(IN_H + IN_W + 2 * PAD + KH + KW + PLANES_PER_MEM + MEM_GROUPS + OUT_GROUPS) + 1;
  state_e state_q, state_d;
  logic valid_q, valid_d, bv_q, bv_d, pad_a_q, pad_a_d, pad_b_q, pad_b_d, last_q, last_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d, fa, fb;
  logic [CW-1:0] og, i, j, mg, p, km, kp;
  logic [6:0] wrap;
  logic cnt_last, hs, load, pa, pb;
  logic signed [SW-1:0] r, ca, cb, row;
  logic unused;
  conv_loop_nest_cnt #(
    .W(CW), .N_OG(OUT_GROUPS), .N_OH(out_dim(IN_H, KH, P, STRIDE)), .N_OW(out_dim(IN_W, KW, P, STRIDE)),
    .N_MG(MEM_GROUPS), .N_PL(PLANES_PER_MEM), .N_KH(KH), .N_KWP(kw_pairs(KW))
  ) u_cnt (
    .clk(clk), .reset(reset), .adv(load), .og(og), .i(i), .j(j), .mg(mg), .p(p), .km(km), .kp(kp),
    .wrap(wrap), .last(cnt_last)
  );
  assign unused = ^{og, mg, wrap};
  // counters always point at the beat to be loaded next into the output register
  always_comb begin
    hs = valid_q && bus.addr_ready;
    load = (state_q == IDLE && start) || (state_q == RUN && hs && !last_q);
    r = SW'(i) * SW'(STRIDE) + SW'(km) - SW'(P);
    ca = SW'(j) * SW'(STRIDE) + SW'({kp, 1'b0}) - SW'(P);
    cb = ca + SW'(1);
    row = SW'(BASE_ADDR) + SW'(p) * SW'(IN_H * IN_W) + r * SW'(IN_W);
    fa = ADDR_W'(row + ca);
    fb = ADDR_W'(row + cb);
`ifdef CONV_PAD_EN
    pa = (r < 0) || (r >= SW'(IN_H)) || (ca < 0) || (ca >= SW'(IN_W));
    pb = (r < 0) || (r >= SW'(IN_H)) || (cb < 0) || (cb >= SW'(IN_W));
    fa = pa ? ADDR_W'(BASE_ADDR) : fa;
    fb = pb ? ADDR_W'(BASE_ADDR) : fb;
`else
    pa = 1'b0;
    pb = 1'b0;
`endif
    state_d = (state_q == IDLE && start) ? RUN :
              (state_q == RUN && hs && last_q) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    valid_d = load || (valid_q && !hs);
    last_d = load ? cnt_last : (last_q && !hs);
    addra_d = load ? fa : addra_q;
    addrb_d = load ? fb : addrb_q;
    bv_d = load ? (32'({kp, 1'b0}) + 1 < KW) : bv_q;
    pad_a_d = load ? pa : pad_a_q;
    pad_b_d = load ? pb : pad_b_q;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      {valid_q, bv_q, pad_a_q, pad_b_q, last_q, busy_q, done_q} <= '0;
      addra_q <= '0;
      addrb_q <= '0;
    end else begin
      state_q <= state_d;
      {valid_q, bv_q, pad_a_q, pad_b_q, last_q, busy_q, done_q} <= {valid_d, bv_d, pad_a_d, pad_b_d, last_d, busy_d, done_d};
      addra_q <= addra_d;
      addrb_q <= addrb_d;
    end
  end
  assign bus.addr_valid = valid_q;
  assign bus.addra = addra_q;
  assign bus.addrb = addrb_q;
  assign bus.b_valid = bv_q;
  assign bus.pad_a = pad_a_q;
  assign bus.pad_b = pad_b_q;
  assign bus.last = last_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_conv_addr_gen_stream.sv
// tb_conv_addr_gen_stream: directed checks of three conv_addr_gen_stream configurations
module tb_conv_addr_gen_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_g = 1'b0;
  logic rdy = 1'b1;
  logic [1:0] sel = 2'd0;
  int checks = 0;
  int errors = 0;
  int span;
  int q_a[$];
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [28:0] p0, p1, p2, obs;
  always #5 clk = ~clk;
  conv_addr_gen_stream_if #(.ADDR_W(11)) b0();
  conv_addr_gen_stream_if #(.ADDR_W(11)) b1();
  conv_addr_gen_stream_if #(.ADDR_W(11)) b2();
  assign b0.addr_ready = rdy;
  assign b1.addr_ready = rdy;
  assign b2.addr_ready = rdy;
  conv_addr_gen_stream #(.ADDR_W(11), .IN_H(6), .IN_W(6), .KH(3), .KW(3)) d0 (
    .clk(clk), .reset(reset), .start(start_g && sel == 2'd0), .bus(b0), .busy(busy0), .done(done0));
  conv_addr_gen_stream #(.ADDR_W(11), .IN_H(7), .IN_W(7), .KH(3), .KW(3), .STRIDE(2)) d1 (
    .clk(clk), .reset(reset), .start(start_g && sel == 2'd1), .bus(b1), .busy(busy1), .done(done1));
  conv_addr_gen_stream #(.ADDR_W(11), .IN_H(4), .IN_W(4), .KH(2), .KW(2), .PLANES_PER_MEM(2), .OUT_GROUPS(2)) d2 (
    .clk(clk), .reset(reset), .start(start_g && sel == 2'd2), .bus(b2), .busy(busy2), .done(done2));
  assign p0 = {b0.addr_valid, b0.addra, b0.addrb, b0.b_valid, b0.pad_a, b0.pad_b, b0.last, busy0, done0};
  assign p1 = {b1.addr_valid, b1.addra, b1.addrb, b1.b_valid, b1.pad_a, b1.pad_b, b1.last, busy1, done1};
  assign p2 = {b2.addr_valid, b2.addra, b2.addrb, b2.b_valid, b2.pad_a, b2.pad_b, b2.last, busy2, done2};
  assign obs = (sel == 2'd0) ? p0 : (sel == 2'd1) ? p1 : p2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_layer(input int ih, input int iw, input int kh, input int kw, input int st,
                           input int pl, input int og, input bit tog, input int spur);
    int oh, ow, kwp, total, n, cyc, first, lastc, a, pix, kp, km, p, i, j;
    logic [28:0] hold;
    bit holding;
    oh = (ih - kh) / st + 1;
    ow = (iw - kw) / st + 1;
    kwp = (kw + 1) / 2;
    total = og * oh * ow * pl * kh * kwp;
    q_a.delete();
    n = 0; cyc = 0; first = -1; lastc = -1; holding = 0; hold = '0;
    @(negedge clk); start_g = 1'b1; rdy = 1'b1;
    @(negedge clk); start_g = 1'b0;
    chk("first_valid", 32'(obs[28]), 32'd1);
    while (n < total && cyc < 5 * total + 20) begin
      if (holding) chk("stable_on_stall", 32'(obs), 32'(hold));
      holding = 0;
      if (obs[28]) begin
        if (first < 0) first = cyc;
        if (tog) rdy = ((cyc - first) % 2 == 0);
        if (rdy) begin
          kp = n % kwp;
          km = (n / kwp) % kh;
          p = (n / (kwp * kh)) % pl;
          pix = n / (kwp * kh * pl);
          j = pix % ow;
          i = (pix / ow) % oh;
          a = p * ih * iw + (i * st + km) * iw + j * st + 2 * kp;
          chk("addra", 32'(obs[27:17]), 32'(a));
          chk("addrb", 32'(obs[16:6]), 32'(a + 1));
          chk("b_valid", 32'(obs[5]), 32'(2 * kp + 1 < kw));
          chk("pads", 32'(obs[4:3]), 32'd0);
          chk("last", 32'(obs[2]), 32'(n == total - 1));
          chk("busy_run", 32'(obs[1]), 32'd1);
          q_a.push_back(int'(obs[27:17]));
          if (n == total - 1) lastc = cyc;
          n++;
        end else begin
          hold = obs;
          holding = 1;
        end
      end
      start_g = (spur > 0 && cyc == spur);
      @(negedge clk);
      cyc++;
    end
    start_g = 1'b0;
    rdy = 1'b1;
    chk("beat_count", 32'(n), 32'(total));
    chk("done_pulse", 32'(obs[0]), 32'd1);
    chk("done_idle_out", 32'({obs[28], obs[2], obs[1]}), 32'd0);
    start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    chk("after_done", 32'({obs[28], obs[1], obs[0]}), 32'd0);
    span = lastc - first + 1;
  endtask

  initial begin
    int n, guard;
    @(negedge clk);
    chk("reset_d0", 32'(p0), 32'd0);
    chk("reset_d1", 32'(p1), 32'd0);
    chk("reset_d2", 32'(p2), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    sel = 2'd0;
    run_layer(6, 6, 3, 3, 1, 1, 1, 1'b0, 0);
    chk("span_cont", 32'(span), 32'd96);
    chk("beat1_addra", 32'(q_a[0]), 32'd0);
    chk("beat2_addra", 32'(q_a[1]), 32'd2);
    chk("beat3_addra", 32'(q_a[2]), 32'd6);
    run_layer(6, 6, 3, 3, 1, 1, 1, 1'b1, 0);
    chk("span_toggle", 32'(span), 32'd191);
    @(negedge clk); start_g = 1'b1;
    @(negedge clk); start_g = 1'b0;
    n = 0; guard = 0;
    while (n < 9 && guard < 50) begin
      if (obs[28]) n++;
      @(negedge clk);
      guard++;
    end
    chk("pre_reset_valid", 32'(obs[28]), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(obs), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", 32'({obs[28], obs[0]}), 32'd0);
    end
    run_layer(6, 6, 3, 3, 1, 1, 1, 1'b0, 5);
    chk("restart_addra", 32'(q_a[0]), 32'd0);
    sel = 2'd1;
    run_layer(7, 7, 3, 3, 2, 1, 1, 1'b0, 0);
    chk("stride_pix01", 32'(q_a[6]), 32'd2);
    chk("stride_final", 32'(q_a[53]), 32'd48);
    sel = 2'd2;
    run_layer(4, 4, 2, 2, 1, 2, 2, 1'b0, 0);
    chk("plane1_start", 32'(q_a[2]), 32'd16);
    for (int k = 0; k < 36; k++) chk("og_repeat", 32'(q_a[k + 36]), 32'(q_a[k]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
